// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: row sense lines in, column strobes and decoded key out.
// The scanner drives through the master modport; the keypad/consumer side uses slave.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with tick-based press/release debounce.
// Emits {row, col} and a one-cycle valid pulse on each accepted key.
module keypad_scanner #(
  parameter int unsigned TICK_DIV       = 27_000,
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DebW  = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    StScan,
    StDebPress,
    StHeld,
    StDebRel
  } state_e;

  // Row synchronizer and scan tick
  logic [3:0]       row_meta_q;
  logic [3:0]       row_s_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;

  assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
      tick_cnt_q <= '0;
    end else begin
      row_meta_q <= kp.row_n;
      row_s_q    <= row_meta_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
    end
  end

  // Scanner state
  state_e          state_q, state_d;
  logic [3:0]      col_n_q, col_n_d;
  logic [1:0]      row_q, row_d;
  logic [DebW-1:0] deb_q, deb_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StScan;
      col_n_q     <= 4'b1110;
      row_q       <= '0;
      deb_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_n_q     <= col_n_d;
      row_q       <= row_d;
      deb_q       <= deb_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Helpers: active column index, lowest low row, saturating debounce increment
  logic [1:0]      col_idx;
  logic [1:0]      low_row;
  logic            any_low;
  logic            latched_high;
  logic [3:0]      col_rot;
  logic [DebW-1:0] deb_inc;
  logic            deb_done;

  always_comb begin
    col_idx = 2'd0;
    unique case (col_n_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_q[i]) low_row = 2'(i);
    end
  end

  assign any_low      = (row_s_q != 4'hF);
  assign latched_high = row_s_q[row_q];
  assign col_rot      = {col_n_q[2:0], col_n_q[3]};
  assign deb_inc      = (deb_q == DebW'(DEBOUNCE_TICKS)) ? deb_q : deb_q + DebW'(1);
  assign deb_done     = (deb_inc >= DebW'(DEBOUNCE_TICKS));

  always_comb begin
    state_d     = state_q;
    col_n_d     = col_n_q;
    row_d       = row_q;
    deb_d       = deb_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (any_low) begin
            row_d   = low_row;
            deb_d   = DebW'(1);
            state_d = StDebPress;
          end else begin
            col_n_d = col_rot;
          end
        end
        StDebPress: begin
          if (!latched_high) begin
            deb_d = deb_inc;
            if (deb_done) begin
              key_code_d  = {row_q, col_idx};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = StHeld;
            end
          end else begin
            // Bounce: abandon this column and keep scanning
            state_d = StScan;
            col_n_d = col_rot;
          end
        end
        StHeld: begin
          if (latched_high) begin
            deb_d   = DebW'(1);
            state_d = StDebRel;
          end
        end
        StDebRel: begin
          if (latched_high) begin
            deb_d = deb_inc;
            if (deb_done) begin
              key_held_d = 1'b0;
              col_n_d    = col_rot;
              state_d    = StScan;
            end
          end else begin
            state_d = StHeld;
          end
        end
      endcase
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix driven by directed and random
// presses, checked cycle by cycle against a tick-level behavioural model.
module tb_keypad_scanner;
  localparam int unsigned TickDiv  = 4;
  localparam int unsigned DebTicks = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .TICK_DIV      (TickDiv),
    .DEBOUNCE_TICKS(DebTicks)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp_if.master)
  );

  // Key matrix: bit (row*4 + col) set means that key is physically closed
  logic [15:0] keys = '0;
  logic [3:0]  row_drv;
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (kp_if.col_n[c] === 1'b0)) row_drv[r] = 1'b0;
      end
    end
  end
  assign kp_if.row_n = row_drv;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int lowest_low(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return 0;
  endfunction

  // Behavioural model, advanced once per clock using pre-edge inputs
  logic [3:0] m_sync1, m_sync2;
  int         m_cnt, m_col, m_row, m_run;
  bit         m_locked, m_held, m_valid, m_live = 1'b0;
  logic [3:0] m_code;

  always @(posedge clk) begin : model
    logic [3:0] rs;
    bit         tk;
    if (rst) begin
      m_sync1 = 4'hF; m_sync2 = 4'hF; m_cnt = 0; m_col = 0; m_row = 0; m_run = 0;
      m_locked = 0; m_held = 0; m_valid = 0; m_code = 4'h0; m_live = 1'b1;
    end else begin
      rs      = m_sync2;
      tk      = (m_cnt == int'(TickDiv) - 1);
      m_cnt   = tk ? 0 : m_cnt + 1;
      m_sync2 = m_sync1;
      m_sync1 = kp_if.row_n;
      m_valid = 0;
      if (tk) begin
        if (!m_locked) begin
          if (rs != 4'hF) begin
            m_locked = 1; m_row = lowest_low(rs); m_run = 1;
          end else m_col = (m_col + 1) % 4;
        end else if (!m_held) begin
          if (!rs[m_row]) begin
            m_run++;
            if (m_run >= int'(DebTicks)) begin
              m_held = 1; m_valid = 1; m_code = 4'(m_row * 4 + m_col); m_run = 0;
            end
          end else begin
            m_locked = 0; m_col = (m_col + 1) % 4;
          end
        end else begin
          // m_run counts consecutive released samples while held
          if (rs[m_row]) begin
            m_run++;
            if (m_run > 1 && m_run >= int'(DebTicks)) begin
              m_held = 0; m_locked = 0; m_run = 0; m_col = (m_col + 1) % 4;
            end
          end else m_run = 0;
        end
      end
    end
  end

  always @(posedge clk) if (m_live && !rst && kp_if.key_valid === 1'b1) n_pulses++;

  always @(negedge clk) begin
    logic [3:0] ec;
    if (m_live) begin
      ec = ~(4'b0001 << m_col);
      check("col_n",     kp_if.col_n,     ec);
      check("key_code",  kp_if.key_code,  m_code);
      check("key_valid", kp_if.key_valid, m_valid);
      check("key_held",  kp_if.key_held,  m_held);
    end
  end

  task automatic wait_held(input logic v, input int budget, input string tag);
    int i = 0;
    while (kp_if.key_held !== v && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, kp_if.key_held, v);
  endtask

  task automatic wait_col(input logic [3:0] c, input int budget);
    int i = 0;
    while (kp_if.col_n !== c && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_col", kp_if.col_n, c);
  endtask

  initial begin
    logic [3:0] seq [4];
    int p, k, hold, gap;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

    // 1. Reset and column rotation
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_col_n", kp_if.col_n, 4'b1110);
    check("rst_code",  kp_if.key_code, 4'h0);
    check("rst_valid", kp_if.key_valid, 1'b0);
    check("rst_held",  kp_if.key_held, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (TickDiv) @(negedge clk);
      check("rotate", kp_if.col_n, seq[i]);
    end

    // 2. Press row2/col1
    p = n_pulses;
    keys[9] = 1'b1;
    wait_held(1'b1, 200, "press_held");
    repeat (8) @(negedge clk);
    check("press_pulses", n_pulses, p + 1);
    check("press_code",   kp_if.key_code, 4'h9);
    check("press_col",    kp_if.col_n, 4'b1101);

    // 4. Release, then a one-tick release glitch
    keys = '0;
    wait_held(1'b0, 100, "release_held");
    check("release_col", kp_if.col_n, 4'b1011);
    wait_col(4'b1101, 40);
    keys[9] = 1'b1;
    wait_held(1'b1, 200, "repress_held");
    repeat (8) @(negedge clk);
    p = n_pulses;
    keys[9] = 1'b0;
    repeat (TickDiv) @(negedge clk);
    keys[9] = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_held",   kp_if.key_held, 1'b1);
    check("glitch_pulses", n_pulses, p);
    keys = '0;
    wait_held(1'b0, 100, "glitch_release");

    // 3. One-tick bounce while scanning
    wait_col(4'b1101, 40);
    p = n_pulses;
    keys[9] = 1'b1;
    repeat (TickDiv) @(negedge clk);
    keys = '0;
    repeat (40) @(negedge clk);
    check("bounce_pulses", n_pulses, p);
    check("bounce_held",   kp_if.key_held, 1'b0);

    // 5. Two rows on column 0: lowest row wins
    p = n_pulses;
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    wait_held(1'b1, 200, "multi_held");
    repeat (8) @(negedge clk);
    check("multi_code",   kp_if.key_code, 4'h4);
    check("multi_pulses", n_pulses, p + 1);

    // 6. Reset while held, then a fresh accept
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_col",   kp_if.col_n, 4'b1110);
    check("midrst_code",  kp_if.key_code, 4'h0);
    check("midrst_valid", kp_if.key_valid, 1'b0);
    check("midrst_held",  kp_if.key_held, 1'b0);
    p = n_pulses;
    wait_held(1'b1, 200, "fresh_held");
    repeat (8) @(negedge clk);
    check("fresh_code",   kp_if.key_code, 4'h4);
    check("fresh_pulses", n_pulses, p + 1);
    keys = '0;
    wait_held(1'b0, 100, "fresh_release");

    // Random presses, holds, glitches and chords against the model
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 15);
      keys = '0;
      keys[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(0, 90);
      repeat (hold) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        keys[k] = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        keys[k] = 1'b1;
        repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      keys = '0;
      gap = $urandom_range(0, 70);
      repeat (gap) @(negedge clk);
    end
    keys = '0;
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
